// File: rtl/regfile_operand_fetch_pkg.sv
// Shared definitions for the register-file operand fetch controller:
// widths, FSM encoding and the x0 helper.
package regfile_operand_fetch_pkg;
  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int NREG = 1 << RA_W;
  localparam logic [RA_W-1:0] X0 = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    READ2 = 1'b1
  } state_t;

  // x0 is hardwired to zero regardless of what the port returns
  function automatic logic [XLEN-1:0] x0Mask(input logic [RA_W-1:0] addr,
                                             input logic [XLEN-1:0] data);
    return (addr == X0) ? '0 : data;
  endfunction
endpackage

// File: rtl/regfile_operand_fetch_if.sv
// Issue, writeback, operand and register-file port signals of the operand
// fetch controller; master is the controller, slave is its environment.
interface regfile_operand_fetch_if;
  import regfile_operand_fetch_pkg::*;

  logic            iss_valid;
  logic            iss_ready;
  logic [RA_W-1:0] iss_rs1;
  logic [RA_W-1:0] iss_rs2;
  logic [RA_W-1:0] iss_rd;
  logic            iss_rd_we;

  logic            wb_valid;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            op_valid;
  logic            op_ready;
  logic [XLEN-1:0] op_rs1_val;
  logic [XLEN-1:0] op_rs2_val;
  logic [RA_W-1:0] op_rd;
  logic            op_rd_we;

  logic            rf_we_a;
  logic [RA_W-1:0] rf_addr_a;
  logic [XLEN-1:0] rf_din_a;
  logic [XLEN-1:0] rf_dout_a;
  logic            rf_we_b;
  logic [RA_W-1:0] rf_addr_b;
  logic [XLEN-1:0] rf_din_b;
  logic [XLEN-1:0] rf_dout_b;

  modport master (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
    input  wb_valid, wb_rd, wb_data,
    input  op_ready,
    input  rf_dout_a, rf_dout_b,
    output iss_ready,
    output op_valid, op_rs1_val, op_rs2_val, op_rd, op_rd_we,
    output rf_we_a, rf_addr_a, rf_din_a, rf_we_b, rf_addr_b, rf_din_b
  );

  modport slave (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
    output wb_valid, wb_rd, wb_data,
    output op_ready,
    output rf_dout_a, rf_dout_b,
    input  iss_ready,
    input  op_valid, op_rs1_val, op_rs2_val, op_rd, op_rd_we,
    input  rf_we_a, rf_addr_a, rf_din_a, rf_we_b, rf_addr_b, rf_din_b
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy bit per architectural register; a set and a clear of the same
// register in one cycle leaves it busy.
module regfile_scoreboard
  import regfile_operand_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            setEn,
  input  logic [RA_W-1:0] setAddr,
  input  logic            clrEn,
  input  logic [RA_W-1:0] clrAddr,
  input  logic [RA_W-1:0] rs1Addr,
  input  logic [RA_W-1:0] rs2Addr,
  input  logic [RA_W-1:0] rdAddr,
  output logic            rs1Busy,
  output logic            rs2Busy,
  output logic            rdBusy
);
  logic [NREG-1:0] busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clrEn) busy[clrAddr] <= 1'b0;
      if (setEn) busy[setAddr] <= 1'b1;
    end
  end

  assign rs1Busy = busy[rs1Addr] && (rs1Addr != X0);
  assign rs2Busy = busy[rs2Addr] && (rs2Addr != X0);
  assign rdBusy  = busy[rdAddr]  && (rdAddr  != X0);
endmodule

// File: rtl/regfile_operand_fetch.sv
// Schedules the two register-file ports between writeback and operand reads,
// stalls RAW/WAW hazards and hands operand bundles to execute.
module regfile_operand_fetch
  import regfile_operand_fetch_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  regfile_operand_fetch_if.master bus
);
  state_t          state;
  logic            wbWr, rs1Busy, rs2Busy, rdBusy, stall, outFree;
  logic            accept, split, capture;
  logic [XLEN-1:0] rs1Val, rs2Val;
  logic [XLEN-1:0] rs1Hold_p1;
  logic [RA_W-1:0] rs2Hold_p1, rdHold_p1;
  logic            rdWeHold_p1;
  logic [RA_W-1:0] capRd;
  logic            capRdWe;

  assign wbWr = bus.wb_valid && (bus.wb_rd != X0);

  regfile_scoreboard sb (
    .clk     (clk),
    .rst     (rst),
    .setEn   (accept && bus.iss_rd_we && (bus.iss_rd != X0)),
    .setAddr (bus.iss_rd),
    .clrEn   (wbWr),
    .clrAddr (bus.wb_rd),
    .rs1Addr (bus.iss_rs1),
    .rs2Addr (bus.iss_rs2),
    .rdAddr  (bus.iss_rd),
    .rs1Busy (rs1Busy),
    .rs2Busy (rs2Busy),
    .rdBusy  (rdBusy)
  );

  // A source produced by this cycle's writeback is not a hazard: rs1 is
  // forwarded, rs2 is read after the write has committed.
  assign stall = (rs1Busy && !(wbWr && (bus.wb_rd == bus.iss_rs1))) ||
                 (rs2Busy && !(wbWr && (bus.wb_rd == bus.iss_rs2))) ||
                 (bus.iss_rd_we && rdBusy);

  assign outFree       = !bus.op_valid || bus.op_ready;
  assign bus.iss_ready = (state == IDLE) && outFree && !stall;
  assign accept        = bus.iss_valid && bus.iss_ready;
  assign split         = accept && wbWr;
  assign capture       = (accept && !wbWr) || (state == READ2);

  assign bus.rf_we_a   = wbWr;
  assign bus.rf_addr_a = wbWr ? bus.wb_rd : bus.iss_rs1;
  assign bus.rf_din_a  = wbWr ? bus.wb_data : '0;
  assign bus.rf_we_b   = 1'b0;
  assign bus.rf_din_b  = '0;
  assign bus.rf_addr_b = (state == READ2) ? rs2Hold_p1 :
                         (wbWr ? bus.iss_rs1 : bus.iss_rs2);

  always_comb begin
    rs1Val  = x0Mask(bus.iss_rs1, bus.rf_dout_a);
    rs2Val  = x0Mask(bus.iss_rs2, bus.rf_dout_b);
    capRd   = bus.iss_rd;
    capRdWe = bus.iss_rd_we;
    if (wbWr) begin
      rs1Val = (bus.iss_rs1 == bus.wb_rd) ? bus.wb_data
                                          : x0Mask(bus.iss_rs1, bus.rf_dout_b);
    end
    if (state == READ2) begin
      rs1Val  = rs1Hold_p1;
      rs2Val  = x0Mask(rs2Hold_p1, bus.rf_dout_b);
      capRd   = rdHold_p1;
      capRdWe = rdWeHold_p1;
    end
  end

  // Stage p1: split-read hold and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rs1Hold_p1     <= '0;
      bus.op_valid   <= 1'b0;
      bus.op_rs1_val <= '0;
      bus.op_rs2_val <= '0;
      bus.op_rd      <= '0;
      bus.op_rd_we   <= 1'b0;
    end else begin
      if (capture) begin
        bus.op_valid   <= 1'b1;
        bus.op_rs1_val <= rs1Val;
        bus.op_rs2_val <= rs2Val;
        bus.op_rd      <= capRd;
        bus.op_rd_we   <= capRdWe;
      end else if (bus.op_ready) begin
        bus.op_valid   <= 1'b0;
        bus.op_rs1_val <= '0;
        bus.op_rs2_val <= '0;
        bus.op_rd      <= '0;
        bus.op_rd_we   <= 1'b0;
      end
      if (state == READ2) state <= IDLE;
      else if (split)     state <= READ2;
      if (split) rs1Hold_p1 <= rs1Val;
    end
  end

  always_ff @(posedge clk) begin
    if (split) begin
      rs2Hold_p1  <= bus.iss_rs2;
      rdHold_p1   <= bus.iss_rd;
      rdWeHold_p1 <= bus.iss_rd_we;
    end
  end
endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: directed vectors and corner sequences, then
// random traffic checked against an architectural register/outstanding-write model.
module tb_regfile_operand_fetch;
  import regfile_operand_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_operand_fetch_if bus ();
  regfile_operand_fetch dut (.clk(clk), .rst(rst), .bus(bus));

  // Register file behaviour: combinational reads, port A reads 0 while writing
  logic [XLEN-1:0] mem [NREG];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (bus.rf_we_a) mem[bus.rf_addr_a] <= bus.rf_din_a;
  end
  always_comb begin
    bus.rf_dout_a = bus.rf_we_a ? '0 : mem[bus.rf_addr_a];
    bus.rf_dout_b = mem[bus.rf_addr_b];
  end

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIss(input logic v, input logic [RA_W-1:0] r1, input logic [RA_W-1:0] r2,
                        input logic [RA_W-1:0] rd, input logic we);
    bus.iss_valid = v; bus.iss_rs1 = r1; bus.iss_rs2 = r2; bus.iss_rd = rd; bus.iss_rd_we = we;
  endtask

  task automatic setWb(input logic v, input logic [RA_W-1:0] rd, input logic [XLEN-1:0] d);
    bus.wb_valid = v; bus.wb_rd = rd; bus.wb_data = d;
  endtask

  task automatic doReset();
    rst = 1'b1;
    setIss(0, 0, 0, 0, 0);
    setWb(0, 0, 0);
    bus.op_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [RA_W-1:0] wbRd;
    logic [XLEN-1:0] wbData;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [XLEN-1:0] exp1;
    logic [XLEN-1:0] exp2;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0] v1;
    logic [XLEN-1:0] v2;
    logic [RA_W-1:0] rd;
    logic            we;
  } bundle_t;

  // Reference model state
  logic [XLEN-1:0] gold [NREG];
  logic [NREG-1:0] pend;
  logic            mRead2, mOutValid;
  bundle_t         mOut, mHeld;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{wbRd: 5'd5,  wbData: 32'h0000_1234, rs1: 5'd5,  rs2: 5'd0,  exp1: 32'h0000_1234, exp2: 32'h0};
    vecs[1] = '{wbRd: 5'd6,  wbData: 32'hDEAD_BEEF, rs1: 5'd6,  rs2: 5'd5,  exp1: 32'hDEAD_BEEF, exp2: 32'h0000_1234};
    vecs[2] = '{wbRd: 5'd0,  wbData: 32'h0000_FFFF, rs1: 5'd0,  rs2: 5'd6,  exp1: 32'h0,         exp2: 32'hDEAD_BEEF};
    vecs[3] = '{wbRd: 5'd10, wbData: 32'h0000_0001, rs1: 5'd10, rs2: 5'd10, exp1: 32'h1,         exp2: 32'h1};
    vecs[4] = '{wbRd: 5'd31, wbData: 32'h8000_0000, rs1: 5'd1,  rs2: 5'd31, exp1: 32'h0,         exp2: 32'h8000_0000};

    doReset();
    @(negedge clk);
    check("rst_op_valid", bus.op_valid, 0);
    check("rst_iss_ready", bus.iss_ready, 1);
    check("rst_op_rs1", bus.op_rs1_val, 0);

    foreach (vecs[i]) begin
      tick(); setWb(1, vecs[i].wbRd, vecs[i].wbData); setIss(0, 0, 0, 0, 0);
      tick(); setWb(0, 0, 0); setIss(1, vecs[i].rs1, vecs[i].rs2, 0, 0);
      @(negedge clk);
      check("vec_ready", bus.iss_ready, 1);
      tick(); setIss(0, 0, 0, 0, 0);
      @(negedge clk);
      check("vec_op_valid", bus.op_valid, 1);
      check("vec_rs1", bus.op_rs1_val, vecs[i].exp1);
      check("vec_rs2", bus.op_rs2_val, vecs[i].exp2);
    end

    // Split read: rs1 forwarded from concurrent writeback, rs2 in READ2
    tick(); setWb(1, 4, 32'h4444);
    tick(); setWb(1, 3, 32'hAAAA); setIss(1, 3, 4, 0, 0);
    @(negedge clk);
    check("split_ready", bus.iss_ready, 1);
    check("split_we_a", bus.rf_we_a, 1);
    tick(); setWb(0, 0, 0); setIss(0, 0, 0, 0, 0);
    @(negedge clk);
    check("read2_ready", bus.iss_ready, 0);
    check("read2_op_valid", bus.op_valid, 0);
    tick();
    @(negedge clk);
    check("split_op_valid", bus.op_valid, 1);
    check("split_rs1", bus.op_rs1_val, 32'hAAAA);
    check("split_rs2", bus.op_rs2_val, 32'h4444);

    // RAW on x7, released by writeback forwarded in the accept cycle
    tick(); setIss(1, 0, 0, 7, 1);
    @(negedge clk);
    check("raw_prod_ready", bus.iss_ready, 1);
    tick(); setIss(1, 7, 0, 0, 0);
    @(negedge clk);
    check("raw_prod_rd", bus.op_rd, 7);
    check("raw_prod_rd_we", bus.op_rd_we, 1);
    check("raw_stall", bus.iss_ready, 0);
    tick();
    @(negedge clk);
    check("raw_stall2", bus.iss_ready, 0);
    tick(); setWb(1, 7, 32'h55);
    @(negedge clk);
    check("raw_release", bus.iss_ready, 1);
    tick(); setWb(0, 0, 0); setIss(0, 0, 0, 0, 0);
    @(negedge clk);
    check("raw_read2_op_valid", bus.op_valid, 0);
    tick();
    @(negedge clk);
    check("raw_op_valid", bus.op_valid, 1);
    check("raw_rs1", bus.op_rs1_val, 32'h55);

    // Backpressure holds the bundle and blocks issue
    tick(); setIss(1, 5, 10, 2, 0);
    @(negedge clk);
    check("hold_accept", bus.iss_ready, 1);
    tick(); setIss(1, 6, 0, 0, 0); bus.op_ready = 1'b0;
    @(negedge clk);
    check("hold_valid", bus.op_valid, 1);
    check("hold_ready_low", bus.iss_ready, 0);
    tick();
    @(negedge clk);
    check("hold_valid2", bus.op_valid, 1);
    check("hold_rs1", bus.op_rs1_val, 32'h1234);
    check("hold_rs2", bus.op_rs2_val, 32'h1);
    check("hold_rd", bus.op_rd, 2);
    check("hold_ready_low2", bus.iss_ready, 0);
    tick(); bus.op_ready = 1'b1;
    @(negedge clk);
    check("release_ready", bus.iss_ready, 1);
    tick(); setIss(0, 0, 0, 0, 0);
    @(negedge clk);
    check("release_valid", bus.op_valid, 1);
    check("release_rs1", bus.op_rs1_val, 32'hDEAD_BEEF);

    // WAW on x9
    tick(); setIss(1, 0, 0, 9, 1);
    @(negedge clk);
    check("waw_first", bus.iss_ready, 1);
    tick();
    @(negedge clk);
    check("waw_stall", bus.iss_ready, 0);
    tick();
    @(negedge clk);
    check("waw_stall2", bus.iss_ready, 0);
    tick(); setWb(1, 9, 32'h99);
    @(negedge clk);
    check("waw_wb_cycle", bus.iss_ready, 0);
    tick(); setWb(0, 0, 0);
    @(negedge clk);
    check("waw_release", bus.iss_ready, 1);
    tick(); setIss(1, 9, 0, 0, 0);
    @(negedge clk);
    check("x9_busy", bus.iss_ready, 0);

    // Reset during READ2
    tick(); setIss(1, 1, 2, 12, 1); setWb(1, 3, 32'h3333);
    @(negedge clk);
    check("pre_rst_split", bus.iss_ready, 1);
    tick(); setIss(0, 0, 0, 0, 0); setWb(0, 0, 0); rst = 1'b1;
    @(negedge clk);
    check("in_read2", bus.iss_ready, 0);
    tick(); rst = 1'b0; setIss(1, 9, 0, 0, 0);
    @(negedge clk);
    check("rst_read2_op_valid", bus.op_valid, 0);
    check("rst_x9_ready", bus.iss_ready, 1);
    tick(); setIss(0, 0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_issue", bus.op_valid, 1);

    // Random traffic against the architectural model
    tick();
    doReset();
    for (int r = 0; r < NREG; r++) gold[r] = '0;
    pend = '0; mRead2 = 1'b0; mOutValid = 1'b0;
    mOut = '{v1: '0, v2: '0, rd: '0, we: 1'b0};
    mHeld = mOut;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int cand[$];
      logic hazard, expReady, accept, wbw;
      bundle_t b;
      setIss($urandom_range(0, 9) < 7,
             ($urandom_range(0, 3) == 0) ? RA_W'($urandom_range(0, 31)) : RA_W'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0) ? RA_W'($urandom_range(0, 31)) : RA_W'($urandom_range(0, 7)),
             RA_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      bus.op_ready = ($urandom_range(0, 3) != 0);
      for (int r = 1; r < NREG; r++) if (pend[r]) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(0, 2) == 0)
        setWb(1, RA_W'(cand[$urandom_range(0, cand.size() - 1)]), $urandom);
      else if ($urandom_range(0, 7) == 0)
        setWb(1, 0, $urandom);
      else
        setWb(0, 0, 0);

      @(negedge clk);
      check("rnd_op_valid", bus.op_valid, mOutValid);
      if (mOutValid) begin
        check("rnd_rs1", bus.op_rs1_val, mOut.v1);
        check("rnd_rs2", bus.op_rs2_val, mOut.v2);
        check("rnd_rd", bus.op_rd, mOut.rd);
        check("rnd_rd_we", bus.op_rd_we, mOut.we);
      end
      wbw = bus.wb_valid && bus.wb_rd != 0;
      hazard = (bus.iss_rs1 != 0 && pend[bus.iss_rs1] && !(wbw && bus.wb_rd == bus.iss_rs1)) ||
               (bus.iss_rs2 != 0 && pend[bus.iss_rs2] && !(wbw && bus.wb_rd == bus.iss_rs2)) ||
               (bus.iss_rd_we && bus.iss_rd != 0 && pend[bus.iss_rd]);
      expReady = !mRead2 && (!mOutValid || bus.op_ready) && !hazard;
      check("rnd_iss_ready", bus.iss_ready, expReady);
      accept = bus.iss_valid && expReady;

      b.v1 = (bus.iss_rs1 == 0) ? '0 : (wbw && bus.wb_rd == bus.iss_rs1) ? bus.wb_data : gold[bus.iss_rs1];
      b.v2 = (bus.iss_rs2 == 0) ? '0 : (wbw && bus.wb_rd == bus.iss_rs2) ? bus.wb_data : gold[bus.iss_rs2];
      b.rd = bus.iss_rd;
      b.we = bus.iss_rd_we;
      if (mRead2) begin
        mOut = mHeld; mOutValid = 1'b1; mRead2 = 1'b0;
      end else if (accept && !wbw) begin
        mOut = b; mOutValid = 1'b1;
      end else begin
        if (bus.op_ready) mOutValid = 1'b0;
        if (accept) begin mRead2 = 1'b1; mHeld = b; end
      end
      if (wbw) begin gold[bus.wb_rd] = bus.wb_data; pend[bus.wb_rd] = 1'b0; end
      if (accept && bus.iss_rd_we && bus.iss_rd != 0) pend[bus.iss_rd] = 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
Initiator-side controller that drives both ports of the team's 32x32 dual-ported register file. It accepts issue requests from decode and writeback requests from the execute/memory stage, and schedules the shared ports between them. A 32-bit scoreboard stalls RAW/WAW hazards, and fetched operands are delivered through a one-entry valid/ready output register to execute.

Parameters:
XLEN, 32, data width of a register
RA_W, 5, register address width (32 entries; x0 reads as zero)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
iss_valid  in  1  issue request valid
iss_ready  out  1  issue request accepted this cycle when high with iss_valid
iss_rs1  in  RA_W  source register 1
iss_rs2  in  RA_W  source register 2
iss_rd  in  RA_W  destination register
iss_rd_we  in  1  instruction writes rd
wb_valid  in  1  writeback valid; always accepted, no ready
wb_rd  in  RA_W  writeback destination
wb_data  in  XLEN  writeback data
op_valid  out  1  operand bundle valid
op_ready  in  1  downstream accepts bundle
op_rs1_val  out  XLEN  operand 1
op_rs2_val  out  XLEN  operand 2
op_rd  out  RA_W  destination, passed through
op_rd_we  out  1  rd write enable, passed through
rf_we_a  out  1  register file port A write enable
rf_addr_a  out  RA_W  port A address
rf_din_a  out  XLEN  port A write data
rf_dout_a  in  XLEN  port A read data (combinational; 0 while port A writes)
rf_we_b  out  1  port B write enable; tied 0
rf_addr_b  out  RA_W  port B address
rf_din_b  out  XLEN  tied 0
rf_dout_b  in  XLEN  port B read data (combinational)

Behaviour:
- Reset (synchronous, rst high at a clk edge): state IDLE, scoreboard all 0, op_valid 0, op_* data 0, internal rs1 hold register 0. Reset during READ2 discards the in-flight instruction.
- Writeback owns port A:
  - wb_valid && wb_rd!=0 -> rf_we_a=1, rf_addr_a=wb_rd, rf_din_a=wb_data, and scoreboard[wb_rd] is cleared at the edge.
  - wb to x0 -> no write, port A stays free.
- Read values: reads of x0 give 0 with no port use and no hazard check.
- Hazard check (IDLE only): stall if rs1 or rs2 is busy and not equal to a wb_rd written this cycle, or if iss_rd_we && iss_rd!=0 && scoreboard[iss_rd] is set (WAW).
- iss_ready = (state==IDLE) && (!op_valid || op_ready) && !stall.
- On accept with iss_rd_we && iss_rd!=0, scoreboard[iss_rd] is set. If the same register is set and cleared in one cycle, set wins.
- FSM IDLE, no port-A write this cycle:
  - rs1 is read on port A and rs2 on port B.
  - Bundle is captured at the edge; op_valid=1 next cycle (latency 1).
- FSM IDLE, port-A write this cycle (split):
  - rs1 is read on port B; if rs1==wb_rd, wb_data is forwarded instead.
  - rs1 goes to the hold register; next state READ2.
- FSM READ2:
  - rs2 is read on port B; the earlier write is already committed, so no forwarding.
  - iss_ready=0. Any wb in this cycle still uses port A.
  - Bundle is captured at the edge, op_valid=1, return to IDLE (latency 2).
- Output register holds its contents while op_valid && !op_ready. It clears when op_ready is high and no new bundle is captured.
- Operand values are the register contents before the issuing instruction's own write (rd==rs allowed).

Decomposition:
- Shared package holds XLEN, RA_W, the FSM state encoding (IDLE, READ2), and the x0 address constant.
- One natural sub-module, regfile_scoreboard: 32 busy bits with set/clear ports, set-wins priority, two combinational busy lookups plus an rd lookup.

Test Plan:
- Reset, write x5=0x1234 via wb; then issue rs1=5, rs2=0, no wb -> op_valid one cycle later, op_rs1_val=0x1234, op_rs2_val=0.
- Issue rs1=3, rs2=4 while wb x3=0xAAAA is active -> rs1 forwarded 0xAAAA via split, rs2 read in READ2; op_valid after 2 cycles, iss_ready low during READ2.
- Issue rd=7 (we), then issue rs1=7 -> iss_ready low until wb x7=0x55, which is forwarded in the accept cycle (op_rs1_val=0x55).
- Hold op_ready=0 with op_valid high -> bundle stable, iss_ready=0. Release op_ready -> next issue accepted the same cycle.
- WAW: issue rd=9, then another issue with rd=9 -> stalls until wb x9 completes.
- Assert rst while in READ2 -> next cycle state IDLE, op_valid=0, scoreboard clear, and an issue of rs1=9 is not stalled.
